// File: rtl/mem_burst_arbiter.sv
// Two-requester round-robin arbiter for wrapping burst reads
// from a shared asynchronous-read memory; read data is registered.
module mem_burst_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] len0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] len1,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_owner,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [AW-1:0] ONE  = 1;
  localparam logic [AW-1:0] ZERO = '0;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          rv_q, rv_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic          rown_q, rown_d;

  logic          pick0;
  logic          pick1;

  // Arbitration: a lone requester wins, ties go to the pointer.
  always_comb begin
    pick0 = req0 & (~req1 | ~ptr_q);
    pick1 = req1 & (~req0 |  ptr_q);
  end

  // State register; synchronous reset aborts any burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
      rown_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      rown_q  <= rown_d;
    end
  end

  // Next-state: grant from IDLE, stream one byte per BURST cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv_d    = 1'b0;
    rdat_d  = rdat_q;
    rown_d  = rown_q;
    unique case (state_q)
      IDLE: begin
        if (pick0) begin
          gnt0_d  = 1'b1;
          cur_d   = addr0;
          cnt_d   = len0;
          owner_d = 1'b0;
          state_d = BURST;
        end else if (pick1) begin
          gnt1_d  = 1'b1;
          cur_d   = addr1;
          cnt_d   = len1;
          owner_d = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        rdat_d = mem_data;
        rv_d   = 1'b1;
        rown_d = owner_q;
        cur_d  = cur_q + ONE;
        if (cnt_q == ZERO) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The burst address register drives memory directly.
  always_comb begin
    mem_addr = cur_q;
    gnt0     = gnt0_q;
    gnt1     = gnt1_q;
    rd_valid = rv_q;
    rd_data  = rdat_q;
    rd_owner = rown_q;
    busy     = (state_q == BURST);
  end

endmodule
